// File: rtl/base_arr_arb_pipe_if.sv
// Bundle of signals between the round-robin arbiter, the registered data
// stage (base_arr_arb_pipe) and its downstream consumer.
//   i_d    per-way payloads, way 0 in the most significant slice
//   arb_v  arbiter valid          arb_r  ready back to the arbiter
//   arb_s  one-hot way select     arb_h  arbiter hold
//   o_v    output valid           o_r    consumer ready
//   o_d    selected payload       o_s    registered select
//   o_e    encoded way index      o_h    registered hold
//   o_err  sticky select-error flag
// slave  : view of the data stage itself
// master : view of the surrounding logic (arbiter plus consumer)
interface base_arr_arb_pipe_if #(
  parameter int ways  = 1,
  parameter int width = 8,
  parameter int encw  = (ways > 1) ? $clog2(ways) : 1
);
  logic [ways*width-1:0] i_d;
  logic                  arb_v;
  logic [ways-1:0]       arb_s;
  logic                  arb_h;
  logic                  arb_r;
  logic                  o_v;
  logic                  o_r;
  logic [width-1:0]      o_d;
  logic [ways-1:0]       o_s;
  logic [encw-1:0]       o_e;
  logic                  o_h;
  logic                  o_err;

  modport slave (
    input  i_d, arb_v, arb_s, arb_h, o_r,
    output arb_r, o_v, o_d, o_s, o_e, o_h, o_err
  );

  modport master (
    output i_d, arb_v, arb_s, arb_h, o_r,
    input  arb_r, o_v, o_d, o_s, o_e, o_h, o_err
  );
endinterface

// File: rtl/base_arr_arb_pipe.sv
// Registered data stage behind the round-robin arbiter. Muxes the winning
// way's payload with the arbiter select and captures {payload, select,
// encoded index, hold} in a 2-entry skid buffer. Ready to the arbiter is
// taken from buffer state only, so no combinational path runs from the
// consumer back to the requesters. Any push whose select is not one-hot
// sets a sticky error flag.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    base_arr_arb_pipe_if.slave (arbiter side and consumer side)
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no entry held; o_v=0, arb_r=1
// ST_ONE   | main entry valid; o_v=1, arb_r=1
// ST_FULL  | main and skid entries valid; o_v=1, arb_r=0
module base_arr_arb_pipe #(
  parameter int ways  = 1,
  parameter int width = 8,
  parameter int encw  = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic               clk,
  input  logic               reset,
  base_arr_arb_pipe_if.slave bus
);

  // entry layout, msb to lsb: payload | select | encoded index | hold
  localparam int EW = width + ways + encw + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  logic             err_q, err_d;
  logic [EW-1:0]    in_ent;
  logic [width-1:0] mux_pay;
  logic [encw-1:0]  mux_enc;
  logic             m_v, s_v, push, pop;

  // AND-OR mux: a zero select yields 0, a multi-hot select ORs its ways.
  // The descending scan leaves the lowest set bit in mux_enc.
  always_comb begin
    mux_pay = '0;
    mux_enc = '0;
    for (int k = ways - 1; k >= 0; k--) begin
      if (bus.arb_s[k]) begin
        mux_pay = mux_pay | bus.i_d[(ways-1-k)*width +: width];
        mux_enc = encw'(k);
      end
    end
  end

  assign in_ent = {mux_pay, bus.arb_s, mux_enc, bus.arb_h};

  assign m_v  = (state_q != ST_EMPTY);
  assign s_v  = (state_q == ST_FULL);
  assign push = bus.arb_v & ~s_v;
  assign pop  = m_v & bus.o_r;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    err_d   = err_q | (push & ~$onehot(bus.arb_s));
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          main_d  = in_ent;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          state_d = ST_FULL;
          skid_d  = in_ent;
        end else if (push && pop) begin
          main_d = in_ent;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // arb_r is low here, so only a pop can happen
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end

  assign bus.arb_r = ~s_v;
  assign bus.o_v   = m_v;
  assign bus.o_d   = main_q[EW-1 -: width];
  assign bus.o_s   = main_q[encw+1 +: ways];
  assign bus.o_e   = main_q[1 +: encw];
  assign bus.o_h   = main_q[0];
  assign bus.o_err = err_q;

endmodule

// File: tb/tb_base_arr_arb_pipe.sv
// Self-checking bench for base_arr_arb_pipe with ways=4, width=8.
module tb_base_arr_arb_pipe;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  base_arr_arb_pipe_if #(.ways(4), .width(8)) bus();

  base_arr_arb_pipe #(.ways(4), .width(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    logic [1:0] e;
    logic       h;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    logic       v;
    int         w;
    logic [7:0] d;
    logic       h;
    logic       r;
    logic       e_ov;
    logic       e_ar;
    logic [7:0] e_od;
    logic       e_err;
  } vec_t;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endfunction

  function automatic sb_t model(input logic [31:0] idv, input logic [3:0] s, input logic h);
    sb_t r;
    r.d = 8'h00;
    r.e = 2'd0;
    r.s = s;
    r.h = h;
    for (int k = 0; k < 4; k++)
      if (s[k]) r.d = r.d | idv[(3-k)*8 +: 8];
    for (int k = 3; k >= 0; k--)
      if (s[k]) r.e = 2'(k);
    return r;
  endfunction

  // scoreboard: push on accepted beats, pop/compare on released beats
  always @(negedge clk) begin
    sb_t e;
    if (!reset) begin
      sbq.delete();
    end else begin
      if (bus.o_v && bus.o_r) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got beat %0h expected none at %0t", bus.o_d, $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_o_d", {24'h0, bus.o_d}, {24'h0, e.d});
          chk("sb_o_s", {28'h0, bus.o_s}, {28'h0, e.s});
          chk("sb_o_e", {30'h0, bus.o_e}, {30'h0, e.e});
          chk("sb_o_h", {31'h0, bus.o_h}, {31'h0, e.h});
        end
      end
      if (bus.arb_v && bus.arb_r)
        sbq.push_back(model(bus.i_d, bus.arb_s, bus.arb_h));
    end
  end

  task automatic drive(input logic v, input logic [3:0] s, input int w,
                       input logic [7:0] d, input logic h, input logic r);
    logic [31:0] dv;
    dv = $urandom;
    if (w >= 0) dv[(3-w)*8 +: 8] = d;
    bus.arb_v = v;
    bus.arb_s = s;
    bus.i_d   = dv;
    bus.arb_h = h;
    bus.o_r   = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    total = 0;
    bad   = 0;

    tbl[0]  = '{1'b1, 2, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1]  = '{1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    tbl[4]  = '{1'b1, 3, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    tbl[5]  = '{1'b1, 3, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    tbl[6]  = '{1'b1, 3, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0};
    tbl[7]  = '{1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 3, 8'h5C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5C, 1'b0};
    tbl[9]  = '{1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5C, 1'b0};
    tbl[10] = '{1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};

    reset = 1'b0;
    drive(1'b0, 4'b0000, -1, 8'h00, 1'b0, 1'b0);
    #2;
    chk("rst_o_v",   {31'h0, bus.o_v},   32'h0);
    chk("rst_arb_r", {31'h0, bus.arb_r}, 32'h1);
    chk("rst_o_d",   {24'h0, bus.o_d},   32'h0);
    chk("rst_o_s",   {28'h0, bus.o_s},   32'h0);
    chk("rst_o_e",   {30'h0, bus.o_e},   32'h0);
    chk("rst_o_h",   {31'h0, bus.o_h},   32'h0);
    chk("rst_o_err", {31'h0, bus.o_err}, 32'h0);
    step();
    step();
    reset = 1'b1;

    // single push, stall fill, hold passthrough
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].v ? (4'b0001 << tbl[i].w) : 4'b0000, tbl[i].w,
            tbl[i].d, tbl[i].h, tbl[i].r);
      step();
      chk($sformatf("vec%0d_o_v", i),   {31'h0, bus.o_v},   {31'h0, tbl[i].e_ov});
      chk($sformatf("vec%0d_arb_r", i), {31'h0, bus.arb_r}, {31'h0, tbl[i].e_ar});
      chk($sformatf("vec%0d_o_err", i), {31'h0, bus.o_err}, {31'h0, tbl[i].e_err});
      if (tbl[i].e_ov)
        chk($sformatf("vec%0d_o_d", i), {24'h0, bus.o_d}, {24'h0, tbl[i].e_od});
    end

    // back-to-back push and pop while ONE
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b0001 << (i % 4), i % 4, 8'h40 + 8'(i), 1'b0, 1'b1);
      step();
      chk("b2b_o_v",   {31'h0, bus.o_v},   32'h1);
      chk("b2b_o_d",   {24'h0, bus.o_d},   32'h40 + i);
      chk("b2b_arb_r", {31'h0, bus.arb_r}, 32'h1);
    end
    drive(1'b0, 4'b0000, -1, 8'h00, 1'b0, 1'b1);
    step();
    chk("b2b_end_o_v", {31'h0, bus.o_v}, 32'h0);

    // multi-hot select: error sets and stays set
    drive(1'b1, 4'b0110, -1, 8'h00, 1'b0, 1'b1);
    bus.i_d = 32'h3C0FF0A5;
    step();
    chk("mh_o_err", {31'h0, bus.o_err}, 32'h1);
    chk("mh_o_d",   {24'h0, bus.o_d},   32'hFF);
    drive(1'b1, 4'b0001, 0, 8'h99, 1'b0, 1'b1);
    step();
    chk("mh_sticky_o_err", {31'h0, bus.o_err}, 32'h1);
    chk("mh_next_o_d",     {24'h0, bus.o_d},   32'h99);
    drive(1'b0, 4'b0000, -1, 8'h00, 1'b0, 1'b1);
    step();
    chk("mh_idle_o_err", {31'h0, bus.o_err}, 32'h1);
    chk("mh_idle_o_v",   {31'h0, bus.o_v},   32'h0);

    // reset clears the error; then a zero select sets it
    reset = 1'b0;
    #1;
    chk("rst2_o_err", {31'h0, bus.o_err}, 32'h0);
    chk("rst2_arb_r", {31'h0, bus.arb_r}, 32'h1);
    step();
    reset = 1'b1;
    drive(1'b1, 4'b0000, -1, 8'h00, 1'b0, 1'b1);
    step();
    chk("zero_o_err", {31'h0, bus.o_err}, 32'h1);
    chk("zero_o_v",   {31'h0, bus.o_v},   32'h1);
    chk("zero_o_d",   {24'h0, bus.o_d},   32'h0);
    chk("zero_o_e",   {30'h0, bus.o_e},   32'h0);

    // fill to FULL, then reset mid-operation
    drive(1'b1, 4'b0010, 1, 8'h21, 1'b0, 1'b0);
    step();
    chk("full_arb_r", {31'h0, bus.arb_r}, 32'h0);
    chk("full_o_v",   {31'h0, bus.o_v},   32'h1);
    reset = 1'b0;
    #1;
    chk("midrst_o_v",   {31'h0, bus.o_v},   32'h0);
    chk("midrst_arb_r", {31'h0, bus.arb_r}, 32'h1);
    chk("midrst_o_err", {31'h0, bus.o_err}, 32'h0);
    step();
    reset = 1'b1;
    drive(1'b1, 4'b0100, 2, 8'h77, 1'b0, 1'b1);
    step();
    chk("post_o_v", {31'h0, bus.o_v}, 32'h1);
    chk("post_o_d", {24'h0, bus.o_d}, 32'h77);
    chk("post_o_e", {30'h0, bus.o_e}, 32'h2);
    drive(1'b0, 4'b0000, -1, 8'h00, 1'b0, 1'b1);
    step();
    chk("post_end_o_v", {31'h0, bus.o_v}, 32'h0);
    step();
    chk("sb_empty", sbq.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
